dac_stream_monitor: RTL and testbench

//  Synthesizable, parametrised capture/checker for the codec DAC serial stream (b_clk, dac_lr_clk, dacdat).

---
 rtl/dac_stream_monitor.sv | 186 ++++++++++++++++++
 tb/tb_dac_stream_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_monitor.sv
// Oversampling capture/checker for the codec DAC serial stream (b_clk, dac_lr_clk, dacdat).
// Frame result 1 clk after the last captured b_clk fall strobe; observe-only, never stalls.

module dsm_period #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_rise,
  output logic [CNT_W-1:0] o_per,
  output logic             o_tmo
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_VAL  = TO_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_idle;
  logic             r_seen;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_idle <= '0;
      r_seen <= 1'b0;
      o_per  <= '0;
      o_tmo  <= 1'b0;
    end else begin
      if (i_rise) begin
        // The first rise only opens a measurement window; nothing to report yet.
        if (r_seen) o_per <= r_cnt;
        r_cnt  <= CNT_W'(1);
        r_seen <= 1'b1;
        r_idle <= '0;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        if (r_idle != TO_VAL) r_idle <= r_idle + 1'b1;
      end
      if (r_idle == TO_VAL) o_tmo <= 1'b1;
    end
  end
endmodule

module dac_stream_monitor #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     b_clk,
  input  logic                     dac_lr_clk,
  input  logic                     dacdat,
  input  logic                     i2s_mode,
  input  logic                     cmp_en,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     mismatch,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     frame_err,
  output logic [CNT_W-1:0]         bclk_per,
  output logic [CNT_W-1:0]         lrclk_per,
  output logic                     bclk_tmo,
  output logic                     lrclk_tmo
);
  localparam int FW   = NUM_CH * DATA_W;
  localparam int SB_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SB_W-1:0]  SLOT_LAST = SB_W'(SLOT_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [SB_W:0]    DATA_LIM  = (SB_W + 1)'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_t;

  // Pin order in the synchroniser vectors: {lr, bclk, dat}.
  logic [2:0]      r_sync1, r_sync2, r_sync3;
  logic            r_lr_rise, r_bclk_rise, r_bclk_fall;
  state_t          r_state;
  logic [FW-1:0]   r_shift;
  logic [SB_W-1:0] r_slot_bit;
  logic [CH_W-1:0] r_slot_idx;
  logic            r_frame_valid;

  logic            w_dat;
  logic            w_data_bit;
  logic            w_last;
  logic [FW-1:0]   w_shift_next;
  logic            w_diff;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync3     <= '0;
      r_lr_rise   <= 1'b0;
      r_bclk_rise <= 1'b0;
      r_bclk_fall <= 1'b0;
    end else begin
      r_sync1     <= {dac_lr_clk, b_clk, dacdat};
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_lr_rise   <= r_sync2[2] & ~r_sync3[2];
      r_bclk_rise <= r_sync2[1] & ~r_sync3[1];
      r_bclk_fall <= ~r_sync2[1] & r_sync3[1];
    end
  end

  // r_sync3 holds the data value that lines up with the registered strobes.
  assign w_dat        = r_sync3[0];
  assign w_data_bit   = ({1'b0, r_slot_bit} < DATA_LIM);
  assign w_last       = (r_slot_bit == SLOT_LAST) && (r_slot_idx == CH_LAST);
  assign w_shift_next = w_data_bit ? FW'({r_shift, w_dat}) : r_shift;
  assign w_diff       = (frame_data != exp_data);
  assign frame_valid  = r_frame_valid;
  assign mismatch     = r_frame_valid & cmp_en & w_diff;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_slot_bit    <= '0;
      r_slot_idx    <= '0;
      r_frame_valid <= 1'b0;
      frame_data    <= '0;
      frame_err     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;

      // An LR rise always restarts the frame and swallows any coincident fall.
      if (r_lr_rise) begin
        if ((r_state == SKIP) || (r_state == SHIFT)) frame_err <= 1'b1;
        r_shift    <= '0;
        r_slot_bit <= '0;
        r_slot_idx <= '0;
        r_state    <= i2s_mode ? SKIP : SHIFT;
      end else begin
        case (r_state)
          SKIP: begin
            if (r_bclk_fall) r_state <= SHIFT;
          end
          SHIFT: begin
            if (r_bclk_fall) begin
              r_shift <= w_shift_next;
              if (r_slot_bit == SLOT_LAST) begin
                r_slot_bit <= '0;
                r_slot_idx <= r_slot_idx + 1'b1;
              end else begin
                r_slot_bit <= r_slot_bit + 1'b1;
              end
              if (w_last) begin
                r_state       <= DONE;
                frame_data    <= w_shift_next;
                r_frame_valid <= 1'b1;
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  dsm_period #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_bclk_per (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rise  (r_bclk_rise),
    .o_per   (bclk_per),
    .o_tmo   (bclk_tmo)
  );

  dsm_period #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_lrclk_per (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rise  (r_lr_rise),
    .o_per   (lrclk_per),
    .o_tmo   (lrclk_tmo)
  );
endmodule

// File: tb/tb_dac_stream_monitor.sv
// Directed bench: dut_a uses 16/16 slots with a short timeout, dut_b uses 24-bit data in 32-bit slots.
// Both share the serial pins; b_clk runs at 8 clk per period, pins change on clk falling edges.

module tb_dac_stream_monitor;
  logic clk = 1'b0;
  logic reset_n, b_clk, dac_lr_clk, dacdat, i2s_mode, cmp_en;
  logic [31:0] exp_a;
  logic [47:0] exp_b;

  logic [31:0] fd_a;
  logic        fv_a, mis_a, ferr_a, btmo_a, ltmo_a;
  logic [15:0] ecnt_a, bper_a, lper_a;
  logic [47:0] fd_b;
  logic        fv_b, mis_b, ferr_b, btmo_b, ltmo_b;
  logic [15:0] ecnt_b, bper_b, lper_b;

  int n_cmp = 0;
  int n_fail = 0;
  int fv_cnt_a = 0;
  int fv_cnt_b = 0;
  logic [31:0] cap_a = '0;
  logic        cap_mis_a = 1'b0;
  logic [47:0] cap_b = '0;
  logic        cap_mis_b = 1'b0;

  always #5 clk = ~clk;

  dac_stream_monitor #(.DATA_W(16), .SLOT_W(16), .NUM_CH(2), .CNT_W(16), .TIMEOUT(100)) dut_a (
    .clk(clk), .reset_n(reset_n), .b_clk(b_clk), .dac_lr_clk(dac_lr_clk), .dacdat(dacdat),
    .i2s_mode(i2s_mode), .cmp_en(cmp_en), .exp_data(exp_a), .frame_data(fd_a),
    .frame_valid(fv_a), .mismatch(mis_a), .err_cnt(ecnt_a), .frame_err(ferr_a),
    .bclk_per(bper_a), .lrclk_per(lper_a), .bclk_tmo(btmo_a), .lrclk_tmo(ltmo_a)
  );

  dac_stream_monitor #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .CNT_W(16), .TIMEOUT(65535)) dut_b (
    .clk(clk), .reset_n(reset_n), .b_clk(b_clk), .dac_lr_clk(dac_lr_clk), .dacdat(dacdat),
    .i2s_mode(i2s_mode), .cmp_en(cmp_en), .exp_data(exp_b), .frame_data(fd_b),
    .frame_valid(fv_b), .mismatch(mis_b), .err_cnt(ecnt_b), .frame_err(ferr_b),
    .bclk_per(bper_b), .lrclk_per(lper_b), .bclk_tmo(btmo_b), .lrclk_tmo(ltmo_b)
  );

  always @(negedge clk) begin
    if (fv_a === 1'b1) begin
      fv_cnt_a++;
      cap_a = fd_a;
      cap_mis_a = mis_a;
    end
    if (fv_b === 1'b1) begin
      fv_cnt_b++;
      cap_b = fd_b;
      cap_mis_b = mis_b;
    end
  end

  // One b_clk period: fall (with new data/lr) then rise, 4 clk each half.
  task automatic drive_bit(input logic d, input logic lr_v);
    b_clk = 1'b0;
    dacdat = d;
    dac_lr_clk = lr_v;
    repeat (4) @(negedge clk);
    b_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic lead();
    drive_bit(1'b0, 1'b1);
  endtask

  task automatic send_bits(input logic [127:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], 1'b0);
  endtask

  task automatic send_frame(input logic [127:0] bits, input int n);
    lead();
    send_bits(bits, n);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
  endtask

  task automatic pulse_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; b_clk = 1'b1; dac_lr_clk = 1'b0; dacdat = 1'b0;
    i2s_mode = 1'b0; cmp_en = 1'b1;
    exp_a = 32'hA5C3_1234; exp_b = 48'hABCDEF_123456;
    repeat (2) @(negedge clk);
    n_cmp++; if (fd_a !== 32'h0) begin n_fail++; $display("FAIL rst_frame_data got %h exp 0", fd_a); end
    n_cmp++; if (fv_a !== 1'b0) begin n_fail++; $display("FAIL rst_frame_valid got %b exp 0", fv_a); end
    n_cmp++; if (mis_a !== 1'b0) begin n_fail++; $display("FAIL rst_mismatch got %b exp 0", mis_a); end
    n_cmp++; if (ecnt_a !== 16'h0) begin n_fail++; $display("FAIL rst_err_cnt got %h exp 0", ecnt_a); end
    n_cmp++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err got %b exp 0", ferr_a); end
    n_cmp++; if (bper_a !== 16'h0) begin n_fail++; $display("FAIL rst_bclk_per got %h exp 0", bper_a); end
    n_cmp++; if (lper_a !== 16'h0) begin n_fail++; $display("FAIL rst_lrclk_per got %h exp 0", lper_a); end
    n_cmp++; if ({btmo_a, ltmo_a} !== 2'b00) begin n_fail++; $display("FAIL rst_tmo got %b exp 00", {btmo_a, ltmo_a}); end
    n_cmp++; if (fd_b !== 48'h0) begin n_fail++; $display("FAIL rst_b_frame_data got %h exp 0", fd_b); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lj_basic();
    int fv0;
    fv0 = fv_cnt_a;
    i2s_mode = 1'b0;
    exp_a = 32'hA5C3_1234;
    send_frame({96'h0, 32'hA5C3_1234}, 32);
    n_cmp++; if (fv_cnt_a - fv0 !== 1) begin n_fail++; $display("FAIL lj_valid_count got %0d exp 1", fv_cnt_a - fv0); end
    n_cmp++; if (cap_a !== 32'hA5C3_1234) begin n_fail++; $display("FAIL lj_data got %h exp a5c31234", cap_a); end
    n_cmp++; if (cap_mis_a !== 1'b0) begin n_fail++; $display("FAIL lj_mismatch got %b exp 0", cap_mis_a); end
    n_cmp++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL lj_frame_err got %b exp 0", ferr_a); end
  endtask

  task automatic test_i2s();
    int fv0;
    fv0 = fv_cnt_a;
    i2s_mode = 1'b1;
    send_frame({95'h0, 1'b1, 32'hA5C3_1234}, 33);
    n_cmp++; if (fv_cnt_a - fv0 !== 1) begin n_fail++; $display("FAIL i2s_valid_count got %0d exp 1", fv_cnt_a - fv0); end
    n_cmp++; if (cap_a !== 32'hA5C3_1234) begin n_fail++; $display("FAIL i2s_data got %h exp a5c31234", cap_a); end
    n_cmp++; if (cap_mis_a !== 1'b0) begin n_fail++; $display("FAIL i2s_mismatch got %b exp 0", cap_mis_a); end
    // In LJ mode the leading 1 is captured and the data slides right one bit.
    i2s_mode = 1'b0;
    send_frame({95'h0, 1'b1, 32'hA5C3_1234}, 33);
    n_cmp++; if (cap_a !== 32'hD2E1_891A) begin n_fail++; $display("FAIL i2s_as_lj_data got %h exp d2e1891a", cap_a); end
    n_cmp++; if (cap_mis_a !== 1'b1) begin n_fail++; $display("FAIL i2s_as_lj_mismatch got %b exp 1", cap_mis_a); end
    n_cmp++; if (ecnt_a !== 16'd1) begin n_fail++; $display("FAIL i2s_as_lj_err_cnt got %0d exp 1", ecnt_a); end
  endtask

  task automatic test_wide_slot();
    int fv0;
    pulse_reset(2);
    fv0 = fv_cnt_b;
    i2s_mode = 1'b0;
    send_frame({64'h0, 24'hABCDEF, 8'hFF, 24'h123456, 8'hFF}, 64);
    n_cmp++; if (fv_cnt_b - fv0 !== 1) begin n_fail++; $display("FAIL wide_valid_count got %0d exp 1", fv_cnt_b - fv0); end
    n_cmp++; if (cap_b !== 48'hABCDEF_123456) begin n_fail++; $display("FAIL wide_data got %h exp abcdef123456", cap_b); end
    n_cmp++; if (cap_mis_b !== 1'b0) begin n_fail++; $display("FAIL wide_mismatch got %b exp 0", cap_mis_b); end
  endtask

  task automatic test_frame_err();
    int fv0;
    fv0 = fv_cnt_a;
    i2s_mode = 1'b0;
    exp_a = 32'h0F0F_F0F0;
    n_cmp++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL ferr_before got %b exp 0", ferr_a); end
    lead();
    send_bits(128'h3FF, 10);
    lead();
    n_cmp++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b exp 1", ferr_a); end
    n_cmp++; if (fv_cnt_a - fv0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid got %0d exp 0", fv_cnt_a - fv0); end
    send_bits({96'h0, 32'h0F0F_F0F0}, 32);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    n_cmp++; if (fv_cnt_a - fv0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count got %0d exp 1", fv_cnt_a - fv0); end
    n_cmp++; if (cap_a !== 32'h0F0F_F0F0) begin n_fail++; $display("FAIL ferr_recover_data got %h exp 0f0ff0f0", cap_a); end
  endtask

  task automatic test_periods();
    pulse_reset(2);
    i2s_mode = 1'b0;
    for (int p = 0; p < 3; p++) begin
      lead();
      repeat (31) drive_bit(1'b0, 1'b0);
    end
    n_cmp++; if (bper_a !== 16'd8) begin n_fail++; $display("FAIL bclk_per got %0d exp 8", bper_a); end
    n_cmp++; if (lper_a !== 16'd256) begin n_fail++; $display("FAIL lrclk_per got %0d exp 256", lper_a); end
    n_cmp++; if (btmo_a !== 1'b0) begin n_fail++; $display("FAIL bclk_tmo_running got %b exp 0", btmo_a); end
    repeat (50) @(negedge clk);
    n_cmp++; if (btmo_a !== 1'b0) begin n_fail++; $display("FAIL bclk_tmo_early got %b exp 0", btmo_a); end
    repeat (100) @(negedge clk);
    n_cmp++; if (btmo_a !== 1'b1) begin n_fail++; $display("FAIL bclk_tmo_set got %b exp 1", btmo_a); end
    n_cmp++; if (bper_a !== 16'd8) begin n_fail++; $display("FAIL bclk_per_hold got %0d exp 8", bper_a); end
    n_cmp++; if (ltmo_a !== 1'b1) begin n_fail++; $display("FAIL lrclk_tmo got %b exp 1", ltmo_a); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    i2s_mode = 1'b0;
    exp_a = 32'h5A5A_C3C3;
    n_cmp++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL mid_ferr_before got %b exp 1", ferr_a); end
    lead();
    send_bits(128'h2AA, 10);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (fd_a !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", fd_a); end
    n_cmp++; if ({fv_a, mis_a, ferr_a, btmo_a, ltmo_a} !== 5'b0) begin n_fail++; $display("FAIL mid_rst_flags got %b exp 00000", {fv_a, mis_a, ferr_a, btmo_a, ltmo_a}); end
    n_cmp++; if ({ecnt_a, bper_a, lper_a} !== 48'h0) begin n_fail++; $display("FAIL mid_rst_counters got %h exp 0", {ecnt_a, bper_a, lper_a}); end
    reset_n = 1'b1;
    fv0 = fv_cnt_a;
    send_frame({96'h0, 32'h5A5A_C3C3}, 32);
    n_cmp++; if (fv_cnt_a - fv0 !== 1) begin n_fail++; $display("FAIL mid_valid_count got %0d exp 1", fv_cnt_a - fv0); end
    n_cmp++; if (cap_a !== 32'h5A5A_C3C3) begin n_fail++; $display("FAIL mid_data got %h exp 5a5ac3c3", cap_a); end
    n_cmp++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL mid_frame_err got %b exp 0", ferr_a); end
    n_cmp++; if (cap_mis_a !== 1'b0) begin n_fail++; $display("FAIL mid_mismatch got %b exp 0", cap_mis_a); end
  endtask

  initial begin
    test_reset();
    test_lj_basic();
    test_i2s();
    test_wide_slot();
    test_frame_err();
    test_periods();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
